// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID/EX hazard signal bundle.
// master = pipeline side, slave = hazard_ctrl.
interface hazard_ctrl_if;
  logic [4:0] id_ra;
  logic [4:0] id_rb;
  logic       id_uses_ra;
  logic       id_uses_rb;
  logic       id_mdstart;
  logic       id_isdiv;
  logic       id_readsHL;
  logic [4:0] ex_rw;
  logic       ex_regWr;
  logic [1:0] ex_memtoreg;
  logic       ex_branch_taken;
  logic       cp0_trap;
  logic       hazard;
  logic       BranchBubble;
  logic       pc_stall;
  logic       ifid_stall;
  logic       ifid_flush;
  logic [1:0] cp0bubble;
  logic       md_busy;
  logic       md_done;

  modport master (
    output id_ra, id_rb,
    output id_uses_ra, id_uses_rb,
    output id_mdstart, id_isdiv,
    output id_readsHL,
    output ex_rw, ex_regWr,
    output ex_memtoreg,
    output ex_branch_taken,
    output cp0_trap,
    input  hazard, BranchBubble,
    input  pc_stall, ifid_stall,
    input  ifid_flush, cp0bubble,
    input  md_busy, md_done
  );

  modport slave (
    input  id_ra, id_rb,
    input  id_uses_ra, id_uses_rb,
    input  id_mdstart, id_isdiv,
    input  id_readsHL,
    input  ex_rw, ex_regWr,
    input  ex_memtoreg,
    input  ex_branch_taken,
    input  cp0_trap,
    output hazard, BranchBubble,
    output pc_stall, ifid_stall,
    output ifid_flush, cp0bubble,
    output md_busy, md_done
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / HI-LO stalls, branch
// flush, mult/div occupancy and CP0 flush phases.
module hazard_ctrl #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32,
  parameter int CNT_W    = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hc
);

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  typedef enum logic [1:0] {
    CP_IDLE = 2'd0,
    CP_F1   = 2'd1,
    CP_F2   = 2'd2
  } cp_state_e;

  localparam logic [CNT_W-1:0] MUL_LOAD =
    CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD =
    CNT_W'(DIV_LAT - 1);

  md_state_e        md_q, md_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cp_state_e        cp_q, cp_d;

  logic lu;
  logic hl;
  logic ra_hit;
  logic rb_hit;
  logic bb;
  logic haz;
  logic md_start;
  logic busy;
  logic cp_f1;

  // Raw hazard terms from ID decode and EX state.
  always_comb begin
    ra_hit = hc.id_uses_ra &&
             (hc.id_ra == hc.ex_rw);
    rb_hit = hc.id_uses_rb &&
             (hc.id_rb == hc.ex_rw);
    lu = hc.ex_regWr &&
         (hc.ex_memtoreg == 2'd1) &&
         (hc.ex_rw != 5'd0) &&
         (ra_hit || rb_hit);
    hl = busy &&
         (hc.id_readsHL || hc.id_mdstart);
    bb = hc.ex_branch_taken;
    // A taken branch discards the stalled
    // instruction, so it overrides the stall.
    haz = (lu || hl) && !bb;
    md_start = hc.id_mdstart && !haz && !bb;
  end

  // Pipeline control outputs.
  always_comb begin
    hc.hazard       = haz;
    hc.BranchBubble = bb;
    hc.pc_stall     = haz || cp_f1;
    hc.ifid_stall   = haz;
    hc.ifid_flush   = bb || cp_f1;
  end

  // Mult/div state and countdown register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_q  <= MD_IDLE;
      cnt_q <= '0;
    end else begin
      md_q  <= md_d;
      cnt_q <= cnt_d;
    end
  end

  // Mult/div next state: load in IDLE,
  // count down in BUSY, leave at zero.
  always_comb begin
    md_d  = md_q;
    cnt_d = cnt_q;
    case (md_q)
      MD_IDLE: begin
        if (md_start) begin
          md_d  = MD_BUSY;
          cnt_d = hc.id_isdiv ? DIV_LOAD
                              : MUL_LOAD;
        end
      end
      MD_BUSY: begin
        if (cnt_q == '0) begin
          md_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        md_d  = MD_IDLE;
        cnt_d = '0;
      end
    endcase
  end

  // Mult/div status outputs.
  always_comb begin
    busy       = (md_q == MD_BUSY);
    hc.md_busy = busy;
    hc.md_done = busy && (cnt_q == '0);
  end

  // CP0 flush phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cp_q <= CP_IDLE;
    end else begin
      cp_q <= cp_d;
    end
  end

  // CP0 next state: a trap starts a fixed
  // two-phase flush; traps mid-flush are dropped.
  always_comb begin
    cp_d = CP_IDLE;
    case (cp_q)
      CP_IDLE: cp_d = hc.cp0_trap ? CP_F1
                                  : CP_IDLE;
      CP_F1:   cp_d = CP_F2;
      CP_F2:   cp_d = CP_IDLE;
      default: cp_d = CP_IDLE;
    endcase
  end

  // CP0 outputs come straight from the state
  // flops, so they settle well before negedge.
  always_comb begin
    cp_f1        = (cp_q == CP_F1);
    hc.cp0bubble = cp_q;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors with
// hand-computed expectations for hazard_ctrl.
module tb_hazard_ctrl;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  hazard_ctrl_if hif ();

  hazard_ctrl #(
    .MULT_LAT(4),
    .DIV_LAT (32),
    .CNT_W   (6)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hc   (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    hif.id_ra           = 5'd0;
    hif.id_rb           = 5'd0;
    hif.id_uses_ra      = 1'b0;
    hif.id_uses_rb      = 1'b0;
    hif.id_mdstart      = 1'b0;
    hif.id_isdiv        = 1'b0;
    hif.id_readsHL      = 1'b0;
    hif.ex_rw           = 5'd0;
    hif.ex_regWr        = 1'b0;
    hif.ex_memtoreg     = 2'd0;
    hif.ex_branch_taken = 1'b0;
    hif.cp0_trap        = 1'b0;
  endtask

  task automatic set_load(
    input logic [4:0] rw,
    input logic [4:0] ra
  );
    hif.ex_regWr    = 1'b1;
    hif.ex_memtoreg = 2'd1;
    hif.ex_rw       = rw;
    hif.id_ra       = ra;
    hif.id_uses_ra  = 1'b1;
  endtask

  int busy_n;
  int done_n;
  int haz_n;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b1;
    idle_in();
    #1 rst_n = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_busy", hif.md_busy, 0);
    check("rst_done", hif.md_done, 0);
    check("rst_cp0b", hif.cp0bubble, 0);
    check("rst_haz", hif.hazard, 0);
    check("rst_pcst", hif.pc_stall, 0);
    next_cyc();
    rst_n = 1'b1;
    next_cyc();

    // load-use on ra
    set_load(5'd5, 5'd5);
    @(negedge clk);
    check("lu_haz", hif.hazard, 1);
    check("lu_pcst", hif.pc_stall, 1);
    check("lu_ifst", hif.ifid_stall, 1);
    check("lu_flush", hif.ifid_flush, 0);
    check("lu_bb", hif.BranchBubble, 0);
    next_cyc();
    // bubble now in EX: stall lasts one cycle
    hif.ex_regWr    = 1'b0;
    hif.ex_memtoreg = 2'd0;
    @(negedge clk);
    check("lu_1cyc", hif.hazard, 0);
    next_cyc();
    // r0 never hazards
    set_load(5'd0, 5'd0);
    @(negedge clk);
    check("lu_r0", hif.hazard, 0);
    next_cyc();
    // rb path
    idle_in();
    hif.ex_regWr    = 1'b1;
    hif.ex_memtoreg = 2'd1;
    hif.ex_rw       = 5'd7;
    hif.id_rb       = 5'd7;
    hif.id_uses_rb  = 1'b1;
    @(negedge clk);
    check("lu_rb", hif.hazard, 1);
    next_cyc();
    // non-load writeback
    hif.ex_memtoreg = 2'd2;
    @(negedge clk);
    check("lu_alu", hif.hazard, 0);
    next_cyc();
    // match but register not read
    hif.ex_memtoreg = 2'd1;
    hif.id_uses_rb  = 1'b0;
    @(negedge clk);
    check("lu_nouse", hif.hazard, 0);
    next_cyc();

    // branch beats stall
    idle_in();
    set_load(5'd9, 5'd9);
    hif.ex_branch_taken = 1'b1;
    @(negedge clk);
    check("br_bb", hif.BranchBubble, 1);
    check("br_haz", hif.hazard, 0);
    check("br_pcst", hif.pc_stall, 0);
    check("br_ifst", hif.ifid_stall, 0);
    check("br_flush", hif.ifid_flush, 1);
    next_cyc();
    idle_in();

    // mult with mfhi waiting; a trap during
    // the mult must not abort it
    hif.id_mdstart = 1'b1;
    @(negedge clk);
    check("mul_c0_busy", hif.md_busy, 0);
    check("mul_c0_haz", hif.hazard, 0);
    next_cyc();
    hif.id_mdstart = 1'b0;
    hif.id_readsHL = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      hif.cp0_trap = (k == 1);
      @(negedge clk);
      check($sformatf("mul_busy%0d", k),
            hif.md_busy, (k <= 4));
      check($sformatf("mul_done%0d", k),
            hif.md_done, (k == 4));
      check($sformatf("mul_haz%0d", k),
            hif.hazard, (k <= 4));
      next_cyc();
    end
    idle_in();
    next_cyc();

    // flushed mdstart never starts
    hif.id_mdstart      = 1'b1;
    hif.ex_branch_taken = 1'b1;
    next_cyc();
    idle_in();
    @(negedge clk);
    check("flush_md", hif.md_busy, 0);
    next_cyc();

    // div, then a second start held in ID
    hif.id_mdstart = 1'b1;
    hif.id_isdiv   = 1'b1;
    next_cyc();
    hif.id_isdiv = 1'b0;
    haz_n  = 0;
    done_n = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (hif.hazard) haz_n++;
      if (hif.md_done) begin
        done_n++;
        check("div_done_at", k, 32);
      end
      next_cyc();
    end
    check("div_haz_n", haz_n, 32);
    check("div_done_n", done_n, 1);
    @(negedge clk);
    check("div2_idle", hif.md_busy, 0);
    check("div2_haz", hif.hazard, 0);
    next_cyc();
    hif.id_mdstart = 1'b0;
    @(negedge clk);
    check("div2_acc", hif.md_busy, 1);
    for (int k = 0; k < 6; k++) next_cyc();
    @(negedge clk);
    check("div2_end", hif.md_busy, 0);
    next_cyc();

    // CP0 sequence, retrigger ignored
    hif.cp0_trap = 1'b1;
    @(negedge clk);
    check("cp_c0", hif.cp0bubble, 0);
    check("cp_c0_pc", hif.pc_stall, 0);
    next_cyc();
    @(negedge clk);
    check("cp_c1", hif.cp0bubble, 1);
    check("cp_c1_pc", hif.pc_stall, 1);
    check("cp_c1_fl", hif.ifid_flush, 1);
    next_cyc();
    hif.cp0_trap = 1'b0;
    @(negedge clk);
    check("cp_c2", hif.cp0bubble, 2);
    check("cp_c2_pc", hif.pc_stall, 0);
    check("cp_c2_fl", hif.ifid_flush, 0);
    next_cyc();
    @(negedge clk);
    check("cp_c3", hif.cp0bubble, 0);
    next_cyc();
    @(negedge clk);
    check("cp_c4", hif.cp0bubble, 0);
    next_cyc();

    // trap together with branch
    hif.cp0_trap        = 1'b1;
    hif.ex_branch_taken = 1'b1;
    @(negedge clk);
    check("cpbr_fl", hif.ifid_flush, 1);
    check("cpbr_bb", hif.BranchBubble, 1);
    next_cyc();
    idle_in();
    @(negedge clk);
    check("cpbr_c1", hif.cp0bubble, 1);
    for (int k = 0; k < 3; k++) next_cyc();

    // async reset in cycle 10 of a div
    hif.id_mdstart = 1'b1;
    hif.id_isdiv   = 1'b1;
    next_cyc();
    idle_in();
    for (int k = 1; k < 10; k++) begin
      hif.cp0_trap = (k == 9);
      next_cyc();
    end
    hif.cp0_trap = 1'b0;
    @(negedge clk);
    check("ar_pre_busy", hif.md_busy, 1);
    check("ar_pre_cp0b", hif.cp0bubble, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("ar_busy", hif.md_busy, 0);
    check("ar_cp0b", hif.cp0bubble, 0);
    check("ar_done", hif.md_done, 0);
    @(negedge clk);
    check("ar_done2", hif.md_done, 0);
    next_cyc();
    rst_n = 1'b1;
    next_cyc();
    hif.id_mdstart = 1'b1;
    next_cyc();
    hif.id_mdstart = 1'b0;
    busy_n = 0;
    done_n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (hif.md_busy) busy_n++;
      if (hif.md_done) done_n++;
      next_cyc();
    end
    check("ar_mul_busy", busy_n, 4);
    check("ar_mul_done", done_n, 1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Produces the stall and bubble controls consumed by the ID/EX pipeline register: `hazard`, `BranchBubble` and `cp0bubble`.
- Also drives the PC and IF/ID hold signals.
- Detects load-use hazards and branch flushes.
- Tracks multi-cycle mult/div occupancy with a counter FSM and sequences two-cycle CP0 trap/eret flushes with a second FSM.
- Sits beside the ID stage; takes inputs from ID decode and the ID/EX register outputs.

Parameters:
- MULT_LAT, 4, cycles a mult occupies HI/LO before results are valid.
- DIV_LAT, 32, cycles a div occupies HI/LO before results are valid.
- CNT_W, 6, width of the mult/div countdown counter; must hold DIV_LAT-1.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_ra  in  5  source register A of the instruction in ID.
- id_rb  in  5  source register B of the instruction in ID.
- id_uses_ra  in  1  ID instruction reads id_ra.
- id_uses_rb  in  1  ID instruction reads id_rb.
- id_mdstart  in  1  ID instruction is mult/multu/div/divu.
- id_isdiv  in  1  qualifies id_mdstart: 1 = div, 0 = mult.
- id_readsHL  in  1  ID instruction is mfhi/mflo/mthi/mtlo.
- ex_rw  in  5  destination register in EX.
- ex_regWr  in  1  EX instruction writes the register file.
- ex_memtoreg  in  2  EX writeback source; 2'd1 = load.
- ex_branch_taken  in  1  branch or jump resolved taken in EX this cycle.
- cp0_trap  in  1  one-cycle pulse from EX: syscall, eret or exception accepted.
- hazard  out  1  freeze IF/ID and insert a bubble into ID/EX.
- BranchBubble  out  1  flush the ID/EX control fields.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold the IF/ID register.
- ifid_flush  out  1  clear the IF/ID register.
- cp0bubble  out  2  CP0 flush phase; ID/EX clears cp0op on the falling edge when this equals 1.
- md_busy  out  1  mult/div in flight.
- md_done  out  1  one-cycle pulse when HI/LO become valid.

Behaviour:
- Reset (async, rst_n=0): both FSMs go to IDLE, counter=0, cp0bubble=0, md_done=0, md_busy=0. The combinational outputs follow from the reset state and inputs. Reset mid-operation abandons any count or flush immediately, with no completion pulse.
- Load-use hazard: `lu = ex_regWr && ex_memtoreg==2'd1 && ex_rw!=0 && ((id_uses_ra && id_ra==ex_rw) || (id_uses_rb && id_rb==ex_rw))`.
- HI/LO hazard: `hl = md_busy && (id_readsHL || id_mdstart)`.
- `hazard = (lu || hl) && !BranchBubble`. This is combinational, so ID/EX samples it at the same rising edge.
- `BranchBubble = ex_branch_taken` (combinational).
- `pc_stall = hazard || (cp0 FSM in F1)`.
- `ifid_stall = hazard`.
- `ifid_flush = BranchBubble || (cp0 FSM in F1)`.
- Priority: branch flush beats a stall. When both are true, the PC loads the target, IF/ID is cleared, and hazard is forced to 0.
- MD FSM, states IDLE and BUSY:
  - IDLE -> BUSY on a rising edge with `id_mdstart && !hazard && !BranchBubble`. The counter loads MULT_LAT-1, or DIV_LAT-1 when id_isdiv=1.
  - In BUSY the counter decrements by 1 each cycle.
  - At counter==0, BUSY -> IDLE and md_done=1 for exactly that one cycle.
  - md_busy=1 exactly while in BUSY, i.e. MULT_LAT cycles for a mult.
  - An mdstart arriving while BUSY is stalled by `hl`; it is accepted on the first IDLE cycle.
  - A flushed mdstart (BranchBubble=1) never starts.
  - cp0_trap does not abort an in-flight mult/div.
- CP0 FSM, states IDLE, F1 and F2:
  - IDLE -> F1 when cp0_trap=1.
  - F1 -> F2 unconditionally; F2 -> IDLE unconditionally.
  - cp0bubble is registered: 0 in IDLE, 2'd1 in F1, 2'd2 in F2. It is stable before the falling edge on which ID/EX samples it.
  - cp0_trap while in F1 or F2 is ignored, with no restart.
  - cp0_trap together with ex_branch_taken in the same cycle: both flushes apply, and the CP0 sequence proceeds.
- All widths are unsigned. The counter never wraps: it is only loaded in IDLE and stops at 0.

Test Plan:
- Load-use: ex_regWr=1, ex_memtoreg=1, ex_rw=5, id_ra=5, id_uses_ra=1 -> hazard=1, pc_stall=1, ifid_stall=1 for exactly 1 cycle. With ex_rw=0 -> hazard=0.
- Mult timing: id_mdstart=1, id_isdiv=0 accepted at edge T -> md_busy=1 for cycles T+1..T+4, md_done pulses at T+4. An mfhi in ID during busy -> hazard=1 until IDLE.
- Div with second start: div accepted, then id_mdstart=1 held -> hazard=1 for 32 cycles, second op accepted the cycle after md_done.
- Branch beats stall: load-use and ex_branch_taken=1 together -> BranchBubble=1, hazard=0, pc_stall=0, ifid_flush=1.
- CP0 sequence: cp0_trap pulse at T -> cp0bubble=1 at T+1, 2 at T+2, 0 at T+3. A second cp0_trap at T+1 is ignored. ifid_flush=1 and pc_stall=1 during F1 only.
- Async reset: assert rst_n=0 during cycle 10 of a div -> md_busy=0 and cp0bubble=0 immediately, no md_done pulse. After release, a new mult counts the full 4 cycles.
